// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-source round-robin mux arbiter.
// Holds the FSM encoding, source/select widths and the 4:1 select mapping.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Same mapping as the 4:1 gate mux: 00->a, 01->b, 10->c, 11->d.
  function automatic logic mux4(input logic [NUM_REQ-1:0] d, input logic [SEL_W-1:0] sel);
    case (sel)
      2'b00:   mux4 = d[0];
      2'b01:   mux4 = d[1];
      2'b10:   mux4 = d[2];
      default: mux4 = d[3];
    endcase
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between the four sources and the arbiter.
// Sources use the master modport; the arbiter uses the slave modport.
interface mux4_rr_arbiter_if;
  import mux4_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] din;
  logic [NUM_REQ-1:0] gnt;
  logic               s1;
  logic               s0;
  logic               y;
  logic               y_valid;

  modport master (output req, din, input gnt, s1, s0, y, y_valid);
  modport slave  (input req, din, output gnt, s1, s0, y, y_valid);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: scans start+1, start+2, start+3, start.
// Reports the first set request bit as winner and whether any bit was set.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = SEL_W'(start + k);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the shared 4:1 one-bit mux; registers gnt, selects and y.
// Define MUX4_ARB_FIXED_PRIO_EN for fixed priority (source 0 highest) instead of round-robin.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned QUANTUM = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux4_rr_arbiter_if.slave    bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(QUANTUM - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               y_q, y_d;
  logic               yv_q, yv_d;

  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   winner;
  logic               any;
  logic               owner_req;
  logic               others;
  logic               load;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  // Starting the scan after index 3 makes the picker strictly 0,1,2,3.
  assign start = 2'd3;
`else
  assign start = ptr_q;
`endif

  rr_pick4 u_pick (
    .req    (bus.req),
    .start  (start),
    .winner (winner),
    .any    (any)
  );

  assign owner_req = bus.req[sel_q];
  assign others    = |(bus.req & ~gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load = any;
      end
      default: begin
        y_d  = mux4(bus.din, sel_q);
        yv_d = owner_req;
        if (owner_req && !(cnt_q == '0 && others)) begin
          // Expiry with nobody else waiting re-grants in place.
          cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
        end else if (any) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
    endcase

    if (load) begin
      state_d = ST_GRANT;
      gnt_d   = onehot(winner);
      sel_d   = winner;
      ptr_d   = winner;
      cnt_d   = RELOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s1      = sel_q[1];
  assign bus.s0      = sel_q[0];
  assign bus.y       = y_q;
  assign bus.y_valid = yv_q;

endmodule
